// File: rtl/ex_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ex_issue_scheduler
// Description : Per-lane issue sequencer and round-robin CDB completion
//               arbiter for an N-lane execute stage (ALU + multiplier/lane).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_issue_scheduler #(
  parameter int N     = 5,
  parameter int CDB_W = 2,
  parameter int TAG_W = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N-1:0]              issue_valid,
  input  logic [N-1:0]              issue_is_mult,
  input  logic [N*TAG_W-1:0]        issue_tag,
  output logic [N-1:0]              issue_ready,
  output logic [N-1:0]              alu_start,
  output logic [N-1:0]              mult_start,
  input  logic [N-1:0]              ex_done,
  output logic [N-1:0]              ex_hold,
  output logic [CDB_W-1:0]          cdb_valid,
  output logic [CDB_W*TAG_W-1:0]    cdb_tag,
  output logic [CDB_W*$clog2(N)-1:0] cdb_lane
);

  localparam int LW = $clog2(N);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_EXEC     = 2'd1;
  localparam logic [1:0] c_WAIT_CDB = 2'd2;

  logic [1:0]         r_state [N];
  logic [TAG_W-1:0]   r_tag   [N];
  logic [N-1:0]       r_alu_start;
  logic [N-1:0]       r_mult_start;
  logic [LW-1:0]      r_rr_ptr;

  logic [N-1:0]       w_grant;
  logic               w_any;
  logic [LW-1:0]      w_last;
  logic [LW-1:0]      w_next_rr;
  logic [CDB_W-1:0]       w_cdb_valid;
  logic [CDB_W*TAG_W-1:0] w_cdb_tag;
  logic [CDB_W*LW-1:0]    w_cdb_lane;
  int                 w_slot;
  int                 w_idx;

  // Per-lane status outputs decoded straight from the registered lane state.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign issue_ready[gi] = (r_state[gi] == c_IDLE);
      assign ex_hold[gi]     = (r_state[gi] == c_WAIT_CDB);
    end
  endgenerate

  assign alu_start  = r_alu_start;
  assign mult_start = r_mult_start;
  assign cdb_valid  = w_cdb_valid;
  assign cdb_tag    = w_cdb_tag;
  assign cdb_lane   = w_cdb_lane;

  // Circular scan from rr_ptr: the first CDB_W waiting lanes fill slots in order.
  always_comb begin
    w_grant     = '0;
    w_any       = 1'b0;
    w_last      = r_rr_ptr;
    w_cdb_valid = '0;
    w_cdb_tag   = '0;
    w_cdb_lane  = '0;
    w_slot      = 0;
    w_idx       = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = (int'(r_rr_ptr) + off) % N;
      if (!flush && (r_state[w_idx] == c_WAIT_CDB) && (w_slot < CDB_W)) begin
        w_grant[w_idx]                      = 1'b1;
        w_cdb_valid[w_slot]                 = 1'b1;
        w_cdb_tag[w_slot*TAG_W +: TAG_W]    = r_tag[w_idx];
        w_cdb_lane[w_slot*LW +: LW]         = LW'(w_idx);
        w_last                              = LW'(w_idx);
        w_any                               = 1'b1;
        w_slot                              = w_slot + 1;
      end
    end
    w_next_rr = (w_last == LW'(N-1)) ? '0 : w_last + LW'(1);
  end

  // Lane sequencers: accept issue, launch one start pulse, wait for done, wait for grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= c_IDLE;
        r_tag[i]   <= '0;
      end
      r_alu_start  <= '0;
      r_mult_start <= '0;
    end else begin
      r_alu_start  <= '0;
      r_mult_start <= '0;
      for (int i = 0; i < N; i++) begin
        if (flush) begin
          r_state[i] <= c_IDLE;
        end else begin
          case (r_state[i])
            c_IDLE: begin
              if (issue_valid[i]) begin
                r_state[i]      <= c_EXEC;
                r_tag[i]        <= issue_tag[i*TAG_W +: TAG_W];
                r_alu_start[i]  <= ~issue_is_mult[i];
                r_mult_start[i] <= issue_is_mult[i];
              end
            end
            c_EXEC: begin
              if (ex_done[i]) r_state[i] <= c_WAIT_CDB;
            end
            c_WAIT_CDB: begin
              if (w_grant[i]) r_state[i] <= c_IDLE;
            end
            default: r_state[i] <= c_IDLE;
          endcase
        end
      end
    end
  end

  // Round-robin pointer advances past the last granted lane; held on flush or idle bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (!flush && w_any) begin
      r_rr_ptr <= w_next_rr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_issue_scheduler
// Description : Self-checking bench for ex_issue_scheduler: directed scenarios
//               with literal expectations plus randomized traffic against a
//               queue-based lane/arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_issue_scheduler;

  localparam int N     = 5;
  localparam int CDB_W = 2;
  localparam int TAG_W = 6;
  localparam int LW    = 3;

  logic                    clock;
  logic                    reset;
  logic                    flush;
  logic [N-1:0]            issue_valid;
  logic [N-1:0]            issue_is_mult;
  logic [N*TAG_W-1:0]      issue_tag;
  logic [N-1:0]            issue_ready;
  logic [N-1:0]            alu_start;
  logic [N-1:0]            mult_start;
  logic [N-1:0]            ex_done;
  logic [N-1:0]            ex_hold;
  logic [CDB_W-1:0]        cdb_valid;
  logic [CDB_W*TAG_W-1:0]  cdb_tag;
  logic [CDB_W*LW-1:0]     cdb_lane;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = executing, 2 = holding result for the CDB
  int               m_state [N];
  logic [TAG_W-1:0] m_tag   [N];
  bit               m_alu   [N];
  bit               m_mul   [N];
  int               m_rr;
  int               gq[$];

  ex_issue_scheduler #(.N(N), .CDB_W(CDB_W), .TAG_W(TAG_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_is_mult (issue_is_mult),
    .issue_tag     (issue_tag),
    .issue_ready   (issue_ready),
    .alu_start     (alu_start),
    .mult_start    (mult_start),
    .ex_done       (ex_done),
    .ex_hold       (ex_hold),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_lane      (cdb_lane)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_tag[i]   = '0;
      m_alu[i]   = 1'b0;
      m_mul[i]   = 1'b0;
    end
    m_rr = 0;
  endfunction

  // Waiting lanes in circular order from the pointer, at most CDB_W of them.
  function automatic void compute_grants();
    gq.delete();
    for (int k = 0; k < N; k++) begin
      int l;
      l = (m_rr + k) % N;
      if (m_state[l] == 2 && gq.size() < CDB_W) gq.push_back(l);
    end
  endfunction

  always @(negedge reset) model_reset();

  // Model advance on every active edge while out of reset.
  always @(posedge clock) begin
    if (reset) begin
      if (flush) begin
        for (int i = 0; i < N; i++) begin
          m_state[i] = 0;
          m_alu[i]   = 1'b0;
          m_mul[i]   = 1'b0;
        end
      end else begin
        bit granted [N];
        compute_grants();
        for (int i = 0; i < N; i++) granted[i] = 1'b0;
        foreach (gq[k]) granted[gq[k]] = 1'b1;
        for (int i = 0; i < N; i++) begin
          m_alu[i] = 1'b0;
          m_mul[i] = 1'b0;
          if (m_state[i] == 0 && issue_valid[i]) begin
            m_state[i] = 1;
            m_tag[i]   = issue_tag[i*TAG_W +: TAG_W];
            m_alu[i]   = ~issue_is_mult[i];
            m_mul[i]   = issue_is_mult[i];
          end else if (m_state[i] == 1 && ex_done[i]) begin
            m_state[i] = 2;
          end else if (m_state[i] == 2 && granted[i]) begin
            m_state[i] = 0;
          end
        end
        if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % N;
      end
    end
  end

  // Compare process: every output, every cycle, against the model.
  always @(negedge clock) begin : p_cmp
    logic [N-1:0]           e_ready, e_hold, e_alu, e_mul;
    logic [CDB_W-1:0]       e_v;
    logic [CDB_W*TAG_W-1:0] e_t;
    logic [CDB_W*LW-1:0]    e_l;
    for (int i = 0; i < N; i++) begin
      e_ready[i] = (m_state[i] == 0);
      e_hold[i]  = (m_state[i] == 2);
      e_alu[i]   = m_alu[i];
      e_mul[i]   = m_mul[i];
    end
    e_v = '0;
    e_t = '0;
    e_l = '0;
    if (!flush) begin
      compute_grants();
      foreach (gq[k]) begin
        e_v[k]                  = 1'b1;
        e_t[k*TAG_W +: TAG_W]   = m_tag[gq[k]];
        e_l[k*LW +: LW]         = LW'(gq[k]);
      end
    end
    chk("issue_ready", 32'(issue_ready), 32'(e_ready));
    chk("ex_hold",     32'(ex_hold),     32'(e_hold));
    chk("alu_start",   32'(alu_start),   32'(e_alu));
    chk("mult_start",  32'(mult_start),  32'(e_mul));
    chk("cdb_valid",   32'(cdb_valid),   32'(e_v));
    chk("cdb_tag",     32'(cdb_tag),     32'(e_t));
    chk("cdb_lane",    32'(cdb_lane),    32'(e_l));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0; flush = 1'b0;
    issue_valid = '0; issue_is_mult = '0; issue_tag = '0; ex_done = '0;
    model_reset();
    #1;
    chk("rst_ready", 32'(issue_ready), 32'(5'b11111));
    chk("rst_cdb",   32'(cdb_valid),   32'(2'b00));
    tick(); tick();
    reset = 1'b1;

    // Five ALU issues, tags 1..5
    issue_valid = '1; issue_is_mult = '0;
    issue_tag = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    tick(); issue_valid = '0;
    @(negedge clock);
    chk("s1_alu",  32'(alu_start),  32'(5'b11111));
    chk("s1_mult", 32'(mult_start), 32'(5'b00000));
    tick(); ex_done = '1;
    tick(); ex_done = '0;
    @(negedge clock);
    chk("s1_vA",   32'(cdb_valid), 32'(2'b11));
    chk("s1_tagA", 32'(cdb_tag),   32'({6'd2, 6'd1}));
    chk("s1_lnA",  32'(cdb_lane),  32'({3'd1, 3'd0}));
    tick(); @(negedge clock);
    chk("s1_tagB", 32'(cdb_tag),     32'({6'd4, 6'd3}));
    chk("s1_rdyB", 32'(issue_ready), 32'(5'b00011));
    tick(); @(negedge clock);
    chk("s1_vC",   32'(cdb_valid),   32'(2'b01));
    chk("s1_tagC", 32'(cdb_tag),     32'({6'd0, 6'd5}));
    chk("s1_rdyC", 32'(issue_ready), 32'(5'b01111));
    tick(); @(negedge clock);
    chk("s1_rdyD", 32'(issue_ready), 32'(5'b11111));

    // Mixed ALU/MULT issue
    issue_valid = '1; issue_is_mult = 5'b11100;
    issue_tag = {6'd14, 6'd13, 6'd12, 6'd11, 6'd10};
    tick(); issue_valid = '0; issue_is_mult = '0;
    @(negedge clock);
    chk("s2_alu",  32'(alu_start),  32'(5'b00011));
    chk("s2_mult", 32'(mult_start), 32'(5'b11100));
    tick(); ex_done = 5'b00011;
    tick(); ex_done = '0;
    @(negedge clock);
    chk("s2_hold1", 32'(ex_hold), 32'(5'b00011));
    chk("s2_tag1",  32'(cdb_tag), 32'({6'd11, 6'd10}));
    tick(); ex_done = 5'b11100;
    @(negedge clock);
    chk("s2_hold2", 32'(ex_hold), 32'(5'b00000));
    tick(); ex_done = '0;
    @(negedge clock);
    chk("s2_hold3", 32'(ex_hold), 32'(5'b11100));
    chk("s2_tag3",  32'(cdb_tag), 32'({6'd13, 6'd12}));
    tick(); @(negedge clock);
    chk("s2_tag4",  32'(cdb_tag), 32'({6'd0, 6'd14}));
    tick();

    // Round-robin wrap: pointer reaches 4 with lanes 4,0,3 waiting
    issue_valid = '1;
    issue_tag = {6'd24, 6'd23, 6'd22, 6'd21, 6'd20};
    tick(); issue_valid = '0;
    tick(); ex_done = 5'b01111;
    tick(); ex_done = '0;
    tick(); issue_valid = 5'b00001; issue_tag = '0; issue_tag[5:0] = 6'd30;
    tick(); issue_valid = 5'b01000; issue_tag = '0; issue_tag[23:18] = 6'd33;
    tick(); issue_valid = '0; ex_done = 5'b11001;
    tick(); ex_done = '0;
    @(negedge clock);
    chk("s3_v1",   32'(cdb_valid), 32'(2'b11));
    chk("s3_tag1", 32'(cdb_tag),   32'({6'd30, 6'd24}));
    chk("s3_ln1",  32'(cdb_lane),  32'({3'd0, 3'd4}));
    tick(); @(negedge clock);
    chk("s3_tag2", 32'(cdb_tag),   32'({6'd0, 6'd33}));
    chk("s3_ln2",  32'(cdb_lane),  32'({3'd0, 3'd3}));
    tick();

    // Flush with lanes 1,2 waiting and lane 3 executing; issue offered on lane 0
    issue_valid = 5'b01110;
    issue_tag = {6'd0, 6'd43, 6'd42, 6'd41, 6'd0};
    tick(); issue_valid = '0;
    tick(); ex_done = 5'b00110;
    tick(); ex_done = '0; flush = 1'b1; issue_valid = 5'b00001;
    @(negedge clock);
    chk("s4_cdb", 32'(cdb_valid), 32'(2'b00));
    tick(); flush = 1'b0; issue_valid = '0; ex_done = 5'b01000;
    @(negedge clock);
    chk("s4_rdy", 32'(issue_ready), 32'(5'b11111));
    chk("s4_alu", 32'(alu_start),   32'(5'b00000));
    tick(); ex_done = '0;
    @(negedge clock);
    chk("s4_rdy2",  32'(issue_ready), 32'(5'b11111));
    chk("s4_hold2", 32'(ex_hold),     32'(5'b00000));

    // Asynchronous reset mid-cycle with busy lanes
    tick();
    issue_valid = '1; issue_is_mult = 5'b10101; issue_tag = 30'h2AAAAAAA;
    tick(); issue_valid = '0; issue_is_mult = '0;
    #2; reset = 1'b0; #1;
    chk("ar_rdy",  32'(issue_ready), 32'(5'b11111));
    chk("ar_alu",  32'(alu_start),   32'(5'b00000));
    chk("ar_mult", 32'(mult_start),  32'(5'b00000));
    chk("ar_cdb",  32'(cdb_valid),   32'(2'b00));
    tick(); tick();
    reset = 1'b1;

    // Randomized traffic against the model
    repeat (3000) begin
      issue_valid   = N'($urandom);
      issue_is_mult = N'($urandom);
      issue_tag     = (N*TAG_W)'($urandom);
      ex_done       = N'($urandom);
      flush         = ($urandom_range(0, 19) == 0);
      tick();
    end
    issue_valid = '0; ex_done = '0; flush = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_issue_scheduler.md
Name: ex_issue_scheduler

Overview:
Per-lane sequencer and completion arbiter for the N-lane execute stage (single-cycle ALU plus multi-cycle multiplier per lane). It accepts instructions issued from the reservation station and drives the per-lane alu_start/mult_start pulses. It tracks each lane's busy/done state and holds finished results in the lane until a CDB slot is granted. Lanes are shared fairly across CDB_W broadcast slots by round-robin arbitration.

Parameters:
N, 5, number of execute lanes (each has one ALU and one multiplier)
CDB_W, 2, CDB broadcast slots per cycle (1 <= CDB_W <= N)
TAG_W, 6, destination physical-register tag width

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous squash of all in-flight lane work
issue_valid  in  N  lane i is offered an instruction this cycle
issue_is_mult  in  N  1 = multiplier op, 0 = ALU op
issue_tag  in  N*TAG_W  destination tag per lane
issue_ready  out  N  lane i is IDLE and can accept
alu_start  out  N  one-cycle start pulse to lane i ALU
mult_start  out  N  one-cycle start pulse to lane i multiplier
ex_done  in  N  execute stage reports lane i result valid
ex_hold  out  N  lane i must hold its result (awaiting CDB)
cdb_valid  out  CDB_W  slot k broadcasts this cycle
cdb_tag  out  CDB_W*TAG_W  tag on slot k
cdb_lane  out  CDB_W*$clog2(N)  source lane of slot k (result mux select)

Behaviour:
- Per-lane FSM states: IDLE, EXEC, WAIT_CDB.
- IDLE: issue_ready[i]=1. On issue_valid[i] && !flush, latch tag and op type and go to EXEC.
- The start pulse is registered. alu_start[i] (or mult_start[i] if is_mult) is 1 for exactly the cycle after acceptance. It is never asserted on both outputs at once.
- EXEC: issue_ready=0. ex_done[i]=1 moves the lane to WAIT_CDB. ex_done is ignored in the cycle the start pulse is high only if the lane has not yet left IDLE. ex_done in IDLE or WAIT_CDB is ignored.
- WAIT_CDB: ex_hold[i]=1 and the lane requests the CDB. When granted, the lane goes to IDLE at the next edge. issue_ready rises the cycle after the grant.
- There is no back-to-back issue into the same lane while it is in EXEC or WAIT_CDB. Minimum lane occupancy is start cycle + done + grant.
- Arbitration is combinational from registered state:
  - Scan lanes circularly starting at rr_ptr and grant the first CDB_W lanes in WAIT_CDB.
  - Slot k carries the k-th grant in scan order. Unused slots have cdb_valid=0 and cdb_tag=0.
  - rr_ptr updates to (last granted lane + 1) mod N and is unchanged if there are no grants. Wrap from N-1 to 0 is required.
- flush=1:
  - All cdb_valid are forced to 0 that cycle.
  - All lanes go to IDLE at the next edge, and start pulses scheduled for the next cycle are cancelled.
  - Issues offered in the flush cycle are not accepted. rr_ptr is unchanged.
- Reset (reset=0, asynchronous, takes effect immediately):
  - All lanes go to IDLE and rr_ptr=0.
  - alu_start, mult_start, ex_hold and cdb_valid are all 0. cdb_tag and cdb_lane are 0.
  - issue_ready is all 1s, both while reset is held and after release.
- Deassertion of reset is synchronous to the internal flops. The first accepted issue is in the first cycle after release.

Test Plan:
- Reset: drive reset=0 mid-cycle with lanes busy -> issue_ready=5'b11111 and alu_start/mult_start/cdb_valid=0 immediately, without waiting for a clock edge.
- Five ALU issues with tags 1..5 in one cycle, and ex_done=5'b11111 the cycle after the starts:
  - alu_start=5'b11111 for one cycle, mult_start=0.
  - CDB output: cycle A tags {1,2} lanes {0,1}; cycle A+1 tags {3,4}; cycle A+2 tag {5}.
  - issue_ready per lane returns 1 the cycle after its grant.
- Mixed issue with is_mult=5'b11100: alu_start=5'b00011 and mult_start=5'b11100. With ex_done for lanes 0,1 at +1 and lanes 2-4 at +3, ALU tags broadcast before MULT tags and ex_hold[2:4] is high only after their ex_done.
- Round-robin wrap: rr_ptr=4 with lanes 4,0,3 waiting -> grants lanes 4,0 (slots 0,1) and rr_ptr=1; next cycle grants lane 3.
- Flush with lanes 1,2 in WAIT_CDB and lane 3 in EXEC -> cdb_valid=0 in the flush cycle, all issue_ready=1 the next cycle, and a later ex_done[3] is ignored.
- Issue offered in the flush cycle (issue_valid[0]=1, flush=1) -> no alu_start next cycle and lane 0 stays IDLE.
